// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache for the MEM-stage load/store port.
// Misses evict a dirty victim, then refill a whole line over a request/grant handshake.
module dcache_wb #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned SET_ADDR_LEN  = 3,
    parameter int unsigned TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     addr,
    input  logic                            rd_req,
    input  logic                            wr_req,
    input  logic [3:0]                      wr_be,
    input  logic [31:0]                     wr_data,
    output logic [31:0]                     rd_data,
    output logic                            miss,
    output logic [31:0]                     mem_addr,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [(32<<LINE_ADDR_LEN)-1:0]  mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]  mem_rd_line,
    input  logic                            mem_gnt,
    output logic [31:0]                     hit_cnt,
    output logic [31:0]                     miss_cnt
);

    localparam int unsigned LINE_WORDS = 1 << LINE_ADDR_LEN;
    localparam int unsigned SETS       = 1 << SET_ADDR_LEN;
    localparam int unsigned OFF_W      = LINE_ADDR_LEN + 2;

    typedef enum logic [1:0] {StIdle, StSwapOut, StSwapIn, StSwapInOk} state_e;

    state_e                                 r_state, w_state_next;
    logic [LINE_WORDS-1:0][31:0]            r_data [SETS];
    logic [TAG_ADDR_LEN-1:0]                r_tag  [SETS];
    logic [SETS-1:0]                        r_valid, r_dirty;
    logic [LINE_WORDS-1:0][31:0]            r_line;
    logic [TAG_ADDR_LEN-1:0]                r_req_tag;
    logic [SET_ADDR_LEN-1:0]                r_req_set;
    logic [31:0]                            r_hit_cnt, r_miss_cnt;

    logic [LINE_ADDR_LEN-1:0]               w_word;
    logic [SET_ADDR_LEN-1:0]                w_set;
    logic [TAG_ADDR_LEN-1:0]                w_tag;
    logic                                   w_req, w_hit;
    logic [31:0]                            w_sel_word, w_merged;
    logic [1:0]                             w_unused_addr;

    assign w_word        = addr[LINE_ADDR_LEN+1:2];
    assign w_set         = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
    assign w_tag         = addr[31 -: TAG_ADDR_LEN];
    assign w_unused_addr = addr[1:0];

    assign w_req      = rd_req | wr_req;
    assign w_hit      = w_req && r_valid[w_set] && (r_tag[w_set] == w_tag) && (r_state == StIdle);
    assign miss       = w_req && !w_hit;
    assign w_sel_word = r_data[w_set][w_word];
    assign rd_data    = w_hit ? w_sel_word : 32'h0;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

    always_comb begin
        w_merged = w_sel_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) w_merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    // Line storage is deliberately unreset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (w_hit && wr_req) r_data[w_set][w_word] <= w_merged;
        if (r_state == StSwapIn && mem_gnt) r_line <= mem_rd_line;
        if (r_state == StSwapInOk) begin
            r_data[r_req_set] <= r_line;
            r_tag[r_req_set]  <= r_req_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_hit_cnt  <= 32'h0;
            r_miss_cnt <= 32'h0;
            r_req_tag  <= '0;
            r_req_set  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_hit) r_hit_cnt <= r_hit_cnt + 32'h1;
            if (w_hit && wr_req) r_dirty[w_set] <= 1'b1;
            if (r_state == StIdle && miss) begin
                r_miss_cnt <= r_miss_cnt + 32'h1;
                r_req_tag  <= w_tag;
                r_req_set  <= w_set;
            end
            if (r_state == StSwapInOk) begin
                r_valid[r_req_set] <= 1'b1;
                r_dirty[r_req_set] <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        mem_addr     = 32'h0;
        mem_wr_line  = '0;
        case (r_state)
            StIdle: begin
                if (miss) begin
                    w_state_next = (r_valid[w_set] && r_dirty[w_set]) ? StSwapOut : StSwapIn;
                end
            end
            StSwapOut: begin
                mem_wr_req  = 1'b1;
                mem_addr    = {r_tag[r_req_set], r_req_set, {OFF_W{1'b0}}};
                mem_wr_line = r_data[r_req_set];
                if (mem_gnt) w_state_next = StSwapIn;
            end
            StSwapIn: begin
                mem_rd_req = 1'b1;
                mem_addr   = {r_req_tag, r_req_set, {OFF_W{1'b0}}};
                if (mem_gnt) w_state_next = StSwapInOk;
            end
            StSwapInOk: w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: hand-computed hit vectors plus refill, eviction and reset sequences.
module tb_dcache_wb;

    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       addr;
    logic              rd_req, wr_req;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic [31:0]       rd_data;
    logic              miss;
    logic [31:0]       mem_addr;
    logic              mem_rd_req, mem_wr_req;
    logic [LINE_W-1:0] mem_wr_line;
    logic [LINE_W-1:0] mem_rd_line;
    logic              mem_gnt;
    logic [31:0]       hit_cnt, miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_wb dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .wr_be       (wr_be),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .miss        (miss),
        .mem_addr    (mem_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_line (mem_wr_line),
        .mem_rd_line (mem_rd_line),
        .mem_gnt     (mem_gnt),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        chk_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a);
        rd_req = rd;
        wr_req = wr;
        addr   = a;
        #1;
    endtask

    // Grants whatever the cache asks for until the held request stops missing.
    task automatic serve(input logic [LINE_W-1:0] line, output int n_wr, output int done);
        n_wr = 0;
        done = 0;
        for (int c = 0; c < 20; c++) begin
            if (!miss) begin
                done = 1;
                break;
            end
            if (mem_wr_req) n_wr++;
            mem_rd_line = line;
            mem_gnt     = mem_wr_req | mem_rd_req;
            step();
            mem_gnt = 1'b0;
        end
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base, input logic fill);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = fill ? base : (base | i);
        return l;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [LINE_W-1:0] line1, line2, line3;
        int nwr, done;

        line1 = mk_line(32'hAAAAAAAA, 1'b1);
        line1[64 +: 32] = 32'hDEADBEEF;
        line2 = mk_line(32'h14000000, 1'b0);
        line3 = mk_line(32'h04000000, 1'b0);

        vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h44, 32'h0,        32'hAAAAAAAA, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 4'h3, 32'h40, 32'h12345678, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h40, 32'h0,        32'hAAAA5678, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 4'hF, 32'h44, 32'h0BADF00D, 32'h0,        1'b0};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h44, 32'h0,        32'h0BADF00D, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 4'hC, 32'h5C, 32'h11223344, 32'h0,        1'b0};
        vecs[6] = '{1'b1, 1'b0, 4'h0, 32'h5C, 32'h0,        32'h1122AAAA, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 4'h4, 32'h48, 32'h00FF0000, 32'h0,        1'b0};
        vecs[8] = '{1'b1, 1'b0, 4'h0, 32'h48, 32'h0,        32'hDEFFBEEF, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0,        32'h0,        1'b1};

        rst = 1'b1; addr = 32'h0; rd_req = 1'b0; wr_req = 1'b0; wr_be = 4'h0;
        wr_data = 32'h0; mem_rd_line = '0; mem_gnt = 1'b0;
        repeat (2) step();
        check("reset_miss", miss, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_hit_cnt", hit_cnt, 0);
        check("reset_miss_cnt", miss_cnt, 0);
        check("reset_mem_rd_req", mem_rd_req, 0);
        check("reset_mem_wr_req", mem_wr_req, 0);
        rst = 1'b0;
        step();

        // Cold miss and refill of line 0x40.
        req(1'b1, 1'b0, 32'h40);
        check("cold_miss", miss, 1);
        check("cold_idle_no_rd_req", mem_rd_req, 0);
        step();
        check("cold_mem_rd_req", mem_rd_req, 1);
        check("cold_mem_wr_req", mem_wr_req, 0);
        check("cold_mem_addr", mem_addr, 32'h40);
        check("cold_miss_cnt", miss_cnt, 1);
        step();
        check("cold_hold_rd_req", mem_rd_req, 1);
        check("cold_hold_addr", mem_addr, 32'h40);
        mem_rd_line = line1;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("cold_req_dropped", mem_rd_req, 0);
        check("cold_miss_in_swapinok", miss, 1);
        step();
        check("cold_retry_hit", miss, 0);
        check("cold_retry_data", rd_data, 32'hAAAAAAAA);
        check("cold_hit_cnt_before", hit_cnt, 0);
        step();
        check("cold_hit_cnt", hit_cnt, 1);
        req(1'b1, 1'b0, 32'h48);
        check("load48_data", rd_data, 32'hDEADBEEF);
        check("load48_miss", miss, 0);
        step();

        for (int i = 0; i < 10; i++) begin
            wr_be = vecs[i].be;
            wr_data = vecs[i].d;
            req(vecs[i].rd, vecs[i].wr, vecs[i].a);
            check($sformatf("vec%0d_miss", i), miss, 0);
            check($sformatf("vec%0d_memreq", i), {31'h0, mem_rd_req | mem_wr_req}, 0);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
            step();
        end
        check("table_hit_cnt", hit_cnt, 11);
        check("table_miss_cnt", miss_cnt, 1);
        wr_be = 4'h0;
        wr_data = 32'h0;

        // Dirty conflict miss: write-back of 0x40 precedes refill of 0x140.
        req(1'b1, 1'b0, 32'h140);
        check("dirty_miss", miss, 1);
        step();
        check("wb_mem_wr_req", mem_wr_req, 1);
        check("wb_mem_rd_req", mem_rd_req, 0);
        check("wb_mem_addr", mem_addr, 32'h40);
        check("wb_word0", mem_wr_line[31:0], 32'hAAAA5678);
        check("wb_word1", mem_wr_line[63:32], 32'h0BADF00D);
        check("wb_word2", mem_wr_line[95:64], 32'hDEFFBEEF);
        check("wb_miss_cnt", miss_cnt, 2);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("wb_done_wr_req", mem_wr_req, 0);
        check("fill_mem_rd_req", mem_rd_req, 1);
        check("fill_mem_addr", mem_addr, 32'h140);
        mem_rd_line = line2;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        check("fill140_miss", miss, 0);
        check("fill140_data", rd_data, 32'h14000000);
        step();
        check("fill140_hit_cnt", hit_cnt, 12);

        // Clean conflict misses never write back.
        req(1'b1, 1'b0, 32'h40);
        serve(line3, nwr, done);
        check("clean40_done", done, 1);
        check("clean40_no_wb", nwr, 0);
        check("clean40_data", rd_data, 32'h04000000);
        check("clean40_miss_cnt", miss_cnt, 3);
        step();
        check("clean40_hit_cnt", hit_cnt, 13);
        req(1'b1, 1'b0, 32'h144);
        serve(line2, nwr, done);
        check("clean144_done", done, 1);
        check("clean144_no_wb", nwr, 0);
        check("clean144_data", rd_data, 32'h14000001);
        check("clean144_miss_cnt", miss_cnt, 4);
        step();
        check("clean144_hit_cnt", hit_cnt, 14);

        // Reset while a refill is pending.
        req(1'b1, 1'b0, 32'h40);
        step();
        check("rst_pre_rd_req", mem_rd_req, 1);
        rst = 1'b1;
        #1;
        check("rst_drops_rd_req", mem_rd_req, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        step();
        rst = 1'b0;
        req(1'b1, 1'b0, 32'h144);
        check("post_rst_miss", miss, 1);
        check("post_rst_idle_no_req", mem_rd_req, 0);
        serve(line2, nwr, done);
        check("post_rst_done", done, 1);
        check("post_rst_data", rd_data, 32'h14000001);
        check("post_rst_miss_cnt", miss_cnt, 1);
        step();
        check("post_rst_hit_cnt", hit_cnt, 1);

        // Stray grant in IDLE is ignored.
        req(1'b0, 1'b0, 32'h0);
        mem_gnt = 1'b1;
        #1;
        check("idle_gnt_rd_req", mem_rd_req, 0);
        check("idle_gnt_wr_req", mem_wr_req, 0);
        step();
        mem_gnt = 1'b0;
        req(1'b1, 1'b0, 32'h144);
        check("idle_gnt_still_hit", miss, 0);
        check("idle_gnt_data", rd_data, 32'h14000001);
        check("idle_gnt_miss_cnt", miss_cnt, 1);
        step();
        check("idle_gnt_hit_cnt", hit_cnt, 2);
        req(1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
